// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - serial line, frame configuration and receive results for uart_rx
// Purpose: groups the receiver's serial input, frame configuration and result outputs.
// Signals:
//   serial_in    serial line, idles high
//   data_width   1 = 8 data bits, 0 = 7 data bits
//   parity_en    1 = parity bit follows the data bits
//   parity_type  0 = even, 1 = odd
//   stop_bits    0 = one stop bit, 1 = two stop bits
//   data_out     received byte (bit 7 is 0 in 7-bit mode)
//   rx_done      one-cycle pulse per completed frame
//   parity_err   parity mismatch, valid with rx_done
//   frame_err    a stop bit was sampled low, valid with rx_done
//   busy         receiver is inside a frame
// Modports: master drives the line and configuration; slave is the receiver.
interface uart_rx_if;
  logic       serial_in;
  logic       data_width;
  logic       parity_en;
  logic       parity_type;
  logic       stop_bits;
  logic [7:0] data_out;
  logic       rx_done;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  modport master (
    output serial_in, data_width, parity_en, parity_type, stop_bits,
    input  data_out, rx_done, parity_err, frame_err, busy
  );

  modport slave (
    input  serial_in, data_width, parity_en, parity_type, stop_bits,
    output data_out, rx_done, parity_err, frame_err, busy
  );
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver with synchroniser, mid-bit sampling and error flags
// Purpose: deframes a 7/8-bit, optional-parity, 1/2-stop-bit UART stream into bytes.
// Ports:
//   clk  single clock, rising edge
//   rst  synchronous active-high reset
//   rx   uart_rx_if.slave (serial line, frame configuration, registered results)
// Parameter CLKS_PER_BIT (>= 1): clock cycles per serial bit.
module uart_rx #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic     clk,
  input  logic     rst,
  uart_rx_if.slave rx
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'((HALF > 0) ? HALF - 1 : 0);
  // With one clock per bit the start sample coincides with start detection,
  // so the start-bit check has nothing left to do and is skipped.
  localparam bit SKIP_START = (HALF == 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;

  state_t          state, state_n;
  logic            sync1, s;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_cnt;
  logic            cfg_w8, cfg_pen, cfg_odd, cfg_stop2;
  logic [7:0]      shreg;
  logic            stop_bad, par_bad;
  logic            bit_tick;
  logic            frame_done;
  logic [2:0]      data_last;
  logic [2:0]      stop_last;
  logic [7:0]      data_bits;

  assign data_last = cfg_w8 ? 3'd7 : 3'd6;
  assign stop_last = {2'b00, cfg_stop2};
  assign data_bits = cfg_w8 ? shreg : {1'b0, shreg[6:0]};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // After the start sample the cycle counter restarts, so every later bit is
  // sampled when it reaches CLKS_PER_BIT-1, one full bit period later.
  always_comb begin
    state_n    = state;
    bit_tick   = (cnt == CNT_LAST);
    frame_done = 1'b0;
    case (state)
      IDLE:      if (!s) state_n = SKIP_START ? DATA : START;
      START:     if (cnt == HALF_LAST) state_n = s ? IDLE : DATA;
      DATA:      if (bit_tick && bit_cnt == data_last) state_n = cfg_pen ? PARITY : STOP;
      PARITY:    if (bit_tick) state_n = STOP;
      STOP: begin
        if (bit_tick && bit_cnt == stop_last) begin
          frame_done = 1'b1;
          state_n    = (stop_bad || !s) ? WAIT_IDLE : IDLE;
        end
      end
      WAIT_IDLE: if (s) state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1         <= 1'b1;
      s             <= 1'b1;
      cnt           <= '0;
      bit_cnt       <= '0;
      cfg_w8        <= 1'b0;
      cfg_pen       <= 1'b0;
      cfg_odd       <= 1'b0;
      cfg_stop2     <= 1'b0;
      shreg         <= '0;
      stop_bad      <= 1'b0;
      par_bad       <= 1'b0;
      rx.data_out   <= '0;
      rx.rx_done    <= 1'b0;
      rx.parity_err <= 1'b0;
      rx.frame_err  <= 1'b0;
      rx.busy       <= 1'b0;
    end else begin
      sync1      <= rx.serial_in;
      s          <= sync1;
      rx.rx_done <= frame_done;
      rx.busy    <= (state_n != IDLE);
      case (state)
        IDLE: begin
          // Configuration is captured continuously while idle and frozen once a frame starts.
          cnt       <= '0;
          bit_cnt   <= '0;
          shreg     <= '0;
          stop_bad  <= 1'b0;
          par_bad   <= 1'b0;
          cfg_w8    <= rx.data_width;
          cfg_pen   <= rx.parity_en;
          cfg_odd   <= rx.parity_type;
          cfg_stop2 <= rx.stop_bits;
        end
        START: cnt <= (cnt == HALF_LAST) ? '0 : cnt + 1'b1;
        DATA: begin
          cnt <= bit_tick ? '0 : cnt + 1'b1;
          if (bit_tick) begin
            shreg[bit_cnt] <= s;
            bit_cnt        <= (bit_cnt == data_last) ? 3'd0 : bit_cnt + 3'd1;
          end
        end
        PARITY: begin
          cnt <= bit_tick ? '0 : cnt + 1'b1;
          if (bit_tick) par_bad <= (s != ((^data_bits) ^ cfg_odd));
        end
        STOP: begin
          cnt <= bit_tick ? '0 : cnt + 1'b1;
          if (bit_tick) begin
            if (!s) stop_bad <= 1'b1;
            bit_cnt <= bit_cnt + 3'd1;
          end
        end
        default: begin
          cnt     <= '0;
          bit_cnt <= '0;
        end
      endcase
      if (frame_done) begin
        rx.data_out   <= data_bits;
        rx.parity_err <= par_bad;
        rx.frame_err  <= stop_bad | ~s;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx at 1 and 4 clocks per bit
module tb_uart_rx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_rx_if if1 ();
  uart_rx_if if4 ();

  uart_rx #(.CLKS_PER_BIT(1)) dut1 (.clk(clk), .rst(rst), .rx(if1));
  uart_rx #(.CLKS_PER_BIT(4)) dut4 (.clk(clk), .rst(rst), .rx(if4));

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int dcyc1[$];
  int dcyc4[$];
  logic [7:0] ddat1[$];
  logic [7:0] ddat4[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (if1.rx_done) begin dcyc1.push_back(cyc); ddat1.push_back(if1.data_out); end
    if (if4.rx_done) begin dcyc4.push_back(cyc); ddat4.push_back(if4.data_out); end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic drive(input int sel, input logic b);
    if (sel == 1) if1.serial_in = b; else if4.serial_in = b;
  endtask

  task automatic set_cfg(input int sel, input logic w8, input logic pen, input logic odd, input logic st2);
    if (sel == 1) begin
      if1.data_width = w8; if1.parity_en = pen; if1.parity_type = odd; if1.stop_bits = st2;
    end else begin
      if4.data_width = w8; if4.parity_en = pen; if4.parity_type = odd; if4.stop_bits = st2;
    end
  endtask

  task automatic idle_line(input int sel);
    @(posedge clk); #1;
    drive(sel, 1'b1);
  endtask

  // Drives one frame; c0 is the cycle index in which the start bit first appears.
  task automatic send(input int sel, input int cpb, input logic [7:0] d, input logic w8,
                      input logic pen, input logic odd, input logic st2,
                      input logic flip_par, input logic stop0, output int c0);
    logic bits[$];
    logic p;
    bits.push_back(1'b0);
    for (int i = 0; i < (w8 ? 8 : 7); i++) bits.push_back(d[i]);
    p = (w8 ? ^d : ^d[6:0]) ^ odd ^ flip_par;
    if (pen) bits.push_back(p);
    repeat (st2 ? 2 : 1) bits.push_back(~stop0);
    c0 = 0;
    for (int i = 0; i < bits.size(); i++) begin
      @(posedge clk); #1;
      if (i == 0) begin
        set_cfg(sel, w8, pen, odd, st2);
        c0 = cyc;
      end
      drive(sel, bits[i]);
      repeat (cpb - 1) @(posedge clk);
    end
  endtask

  task automatic wait_q(input int sel, input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      if ((sel == 1 ? dcyc1.size() : dcyc4.size()) >= n) break;
      @(posedge clk);
    end
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1, 1'b1); drive(4, 1'b1);
    set_cfg(1, 1'b1, 1'b0, 1'b0, 1'b0);
    set_cfg(4, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    checks++; if (if1.data_out !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", if1.data_out); end
    checks++; if ({if1.rx_done, if1.parity_err, if1.frame_err, if1.busy} !== 4'b0000)
      begin errors++; $display("FAIL reset_flags: got %b want 0000", {if1.rx_done, if1.parity_err, if1.frame_err, if1.busy}); end
    checks++; if ({if4.data_out, if4.rx_done, if4.busy} !== 10'h000)
      begin errors++; $display("FAIL reset_cpb4: got %h want 000", {if4.data_out, if4.rx_done, if4.busy}); end
    rst = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_8n1();
    int n0, c0, lat;
    n0 = dcyc1.size();
    send(1, 1, 8'hF0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, c0);
    idle_line(1);
    wait_q(1, n0 + 1, 40);
    checks++; if (dcyc1.size() !== n0 + 1) begin errors++; $display("FAIL 8n1_f0_count: got %0d want %0d", dcyc1.size(), n0 + 1); end
    checks++; if (if1.data_out !== 8'hF0) begin errors++; $display("FAIL 8n1_f0_data: got %h want f0", if1.data_out); end
    checks++; if ({if1.parity_err, if1.frame_err} !== 2'b00) begin errors++; $display("FAIL 8n1_f0_err: got %b want 00", {if1.parity_err, if1.frame_err}); end
    n0 = dcyc1.size();
    send(1, 1, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, c0);
    idle_line(1);
    wait_q(1, n0 + 1, 40);
    lat = (dcyc1.size() > n0) ? dcyc1[n0] - c0 : -1;
    checks++; if (if1.data_out !== 8'h5A) begin errors++; $display("FAIL 8n1_5a_data: got %h want 5a", if1.data_out); end
    checks++; if ({if1.parity_err, if1.frame_err} !== 2'b00) begin errors++; $display("FAIL 8n1_5a_err: got %b want 00", {if1.parity_err, if1.frame_err}); end
    checks++; if (lat !== 12) begin errors++; $display("FAIL 8n1_latency: got %0d want 12", lat); end
  endtask

  task automatic test_parity();
    int n0, c0;
    n0 = dcyc1.size();
    send(1, 1, 8'h0F, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, c0);
    idle_line(1);
    wait_q(1, n0 + 1, 40);
    checks++; if ({if1.data_out, if1.parity_err} !== {8'h0F, 1'b0}) begin errors++; $display("FAIL 8o1_good: got %h/%b want 0f/0", if1.data_out, if1.parity_err); end
    n0 = dcyc1.size();
    send(1, 1, 8'h0F, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, c0);
    idle_line(1);
    wait_q(1, n0 + 1, 40);
    checks++; if (dcyc1.size() !== n0 + 1) begin errors++; $display("FAIL 8o1_bad_count: got %0d want %0d", dcyc1.size(), n0 + 1); end
    checks++; if (if1.parity_err !== 1'b1) begin errors++; $display("FAIL 8o1_bad_perr: got %b want 1", if1.parity_err); end
    checks++; if ({if1.data_out, if1.frame_err} !== {8'h0F, 1'b0}) begin errors++; $display("FAIL 8o1_bad_data: got %h/%b want 0f/0", if1.data_out, if1.frame_err); end
  endtask

  task automatic test_seven_bit();
    int n0, c0, lat;
    n0 = dcyc1.size();
    send(1, 1, 8'h2A, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, c0);
    idle_line(1);
    wait_q(1, n0 + 1, 40);
    lat = (dcyc1.size() > n0) ? dcyc1[n0] - c0 : -1;
    checks++; if ({if1.data_out, if1.parity_err, if1.frame_err} !== {8'h2A, 2'b00}) begin errors++; $display("FAIL 7o2_data: got %h/%b%b want 2a/00", if1.data_out, if1.parity_err, if1.frame_err); end
    checks++; if (lat !== 13) begin errors++; $display("FAIL 7o2_latency: got %0d want 13", lat); end
    n0 = dcyc1.size();
    send(1, 1, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, c0);
    idle_line(1);
    wait_q(1, n0 + 1, 40);
    checks++; if (dcyc1.size() !== n0 + 1) begin errors++; $display("FAIL 7n1_count: got %0d want %0d", dcyc1.size(), n0 + 1); end
    checks++; if (if1.data_out !== 8'h2A) begin errors++; $display("FAIL 7n1_data: got %h want 2a", if1.data_out); end
  endtask

  task automatic test_frame_err();
    int n0, c0;
    n0 = dcyc1.size();
    send(1, 1, 8'hF0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, c0);
    repeat (6) @(posedge clk);
    #1;
    checks++; if (if1.busy !== 1'b1) begin errors++; $display("FAIL ferr_busy_low_line: got %b want 1", if1.busy); end
    drive(1, 1'b1);
    repeat (8) @(posedge clk);
    #1;
    checks++; if (dcyc1.size() !== n0 + 1) begin errors++; $display("FAIL ferr_count: got %0d want %0d", dcyc1.size(), n0 + 1); end
    checks++; if ({if1.data_out, if1.frame_err, if1.parity_err} !== {8'hF0, 2'b10}) begin errors++; $display("FAIL ferr_flags: got %h/%b%b want f0/10", if1.data_out, if1.frame_err, if1.parity_err); end
    checks++; if (if1.busy !== 1'b0) begin errors++; $display("FAIL ferr_busy_release: got %b want 0", if1.busy); end
  endtask

  task automatic test_back_to_back();
    int n0, c0, c1, gap;
    logic [7:0] d0, d1;
    n0 = dcyc1.size();
    send(1, 1, 8'h9E, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, c0);
    send(1, 1, 8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, c1);
    idle_line(1);
    wait_q(1, n0 + 2, 60);
    gap = (dcyc1.size() > n0 + 1) ? dcyc1[n0 + 1] - dcyc1[n0] : -1;
    d0 = (dcyc1.size() > n0) ? ddat1[n0] : 8'hXX;
    d1 = (dcyc1.size() > n0 + 1) ? ddat1[n0 + 1] : 8'hXX;
    checks++; if (dcyc1.size() !== n0 + 2) begin errors++; $display("FAIL b2b_count: got %0d want %0d", dcyc1.size(), n0 + 2); end
    checks++; if (d0 !== 8'h9E) begin errors++; $display("FAIL b2b_first: got %h want 9e", d0); end
    checks++; if (d1 !== 8'h01) begin errors++; $display("FAIL b2b_second: got %h want 01", d1); end
    checks++; if (gap !== 11) begin errors++; $display("FAIL b2b_gap: got %0d want 11", gap); end
    checks++; if ({if1.parity_err, if1.frame_err} !== 2'b00) begin errors++; $display("FAIL b2b_err: got %b want 00", {if1.parity_err, if1.frame_err}); end
  endtask

  task automatic test_cpb4_frame(input logic [7:0] d);
    int n0, c0, lat;
    n0 = dcyc4.size();
    send(4, 4, d, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, c0);
    idle_line(4);
    wait_q(4, n0 + 1, 100);
    lat = (dcyc4.size() > n0) ? dcyc4[n0] - c0 : -1;
    checks++; if (if4.data_out !== d) begin errors++; $display("FAIL cpb4_data: got %h want %h", if4.data_out, d); end
    checks++; if ({if4.parity_err, if4.frame_err} !== 2'b00) begin errors++; $display("FAIL cpb4_err: got %b want 00", {if4.parity_err, if4.frame_err}); end
    checks++; if (lat !== 41) begin errors++; $display("FAIL cpb4_latency: got %0d want 41", lat); end
  endtask

  task automatic test_false_start();
    int n0;
    logic saw_busy;
    n0 = dcyc4.size();
    saw_busy = 1'b0;
    @(posedge clk); #1; drive(4, 1'b0);
    @(posedge clk); #1; drive(4, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (if4.busy) saw_busy = 1'b1;
    end
    checks++; if (saw_busy !== 1'b1) begin errors++; $display("FAIL glitch_detect: got %b want 1", saw_busy); end
    checks++; if (if4.busy !== 1'b0) begin errors++; $display("FAIL glitch_busy: got %b want 0", if4.busy); end
    repeat (50) @(posedge clk);
    #1;
    checks++; if (dcyc4.size() !== n0) begin errors++; $display("FAIL glitch_no_done: got %0d want %0d", dcyc4.size(), n0); end
  endtask

  task automatic test_reset_mid_frame();
    int n0;
    logic b[5];
    b[0] = 1'b0; b[1] = 1'b0; b[2] = 1'b1; b[3] = 1'b0; b[4] = 1'b1;
    n0 = dcyc4.size();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (i == 0) set_cfg(4, 1'b1, 1'b0, 1'b0, 1'b0);
      drive(4, b[i]);
      if (i < 4) repeat (3) @(posedge clk);
    end
    @(posedge clk); #1;
    checks++; if (if4.busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before: got %b want 1", if4.busy); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if ({if4.data_out, if4.rx_done, if4.parity_err, if4.frame_err, if4.busy} !== 12'h000)
      begin errors++; $display("FAIL rstmid_outputs: got %h want 000", {if4.data_out, if4.rx_done, if4.parity_err, if4.frame_err, if4.busy}); end
    rst = 1'b0;
    drive(4, 1'b1);
    repeat (60) @(posedge clk);
    #1;
    checks++; if (dcyc4.size() !== n0) begin errors++; $display("FAIL rstmid_no_done: got %0d want %0d", dcyc4.size(), n0); end
  endtask

  initial begin
    if1.serial_in = 1'b1;
    if4.serial_in = 1'b1;
    set_cfg(1, 1'b1, 1'b0, 1'b0, 1'b0);
    set_cfg(4, 1'b1, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_8n1();
    test_parity();
    test_seven_bit();
    test_frame_err();
    test_back_to_back();
    test_cpb4_frame(8'hC3);
    test_false_start();
    test_reset_mid_frame();
    test_cpb4_frame(8'h5A);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver that deframes the UART bit stream produced by the transmitter stage (`tx`) and presents parallel bytes with error flags. Sits directly downstream of `tx` (its `serial_in` connects to `tx.serial_out`), sharing the same frame configuration:
- 7/8 data bits, LSB first;
- optional even/odd parity;
- 1 or 2 stop bits.

Includes input synchronisation, optional mid-bit sampling for `CLKS_PER_BIT > 1`, false-start rejection and frame/parity error detection.

## Interface
- `CLKS_PER_BIT`, default 1: clock cycles per serial bit. Must be ≥ 1. The default of 1 matches `tx`, which shifts one bit per clock.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `serial_in`  in  1  serial line; idles high.
- `data_width`  in  1  1 = 8 data bits, 0 = 7 data bits.
- `parity_en`  in  1  1 = parity bit present after the data bits.
- `parity_type`  in  1  0 = even, 1 = odd.
- `stop_bits`  in  1  0 = one stop bit, 1 = two stop bits.
- `data_out`  out  8  received data. In 7-bit mode, `data_out[7]` = 0.
- `rx_done`  out  1  one-cycle pulse per completed frame.
- `parity_err`  out  1  valid with `rx_done`. Set when parity is enabled and the parity bit mismatches.
- `frame_err`  out  1  valid with `rx_done`. Set when any configured stop bit is sampled 0.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- **Synchroniser:** a 2-flop synchroniser on `serial_in` produces `s`. Both flops reset to 1. All FSM decisions use `s`.
- **FSM states:** IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
- **Counters:**
  - cycle counter, 0..CLKS_PER_BIT-1;
  - bit counter, 0..7.
- **IDLE:**
  - When `s == 0`, go to START. Clear the counters.
  - Latch `data_width`, `parity_en`, `parity_type` and `stop_bits`. The latched values govern the whole frame; changes to these inputs mid-frame are ignored.
- **Sample instants:** frame bit k (start = 0) is sampled at `t + floor(CPB/2) + k*CPB`, where `t` is the first cycle with `s == 0` in IDLE.
- **START:**
  - At the mid-start sample, if `s == 1`: false start. Return to IDLE with no output change.
  - Otherwise go to DATA.
  - For CPB = 1 the sample is at `t` itself, so a start is always accepted.
- **DATA:** shift the sample into `data_out` bit position = bit counter. Sample 7 or 8 bits, then go to PARITY if enabled, else STOP.
- **PARITY:** compute `p = ^received_data_bits`, inverted if odd. `parity_err = (sample != p)`.
  - In 7-bit mode parity covers bits [6:0] only.
- **STOP:**
  - Sample 1 or 2 stop bits. Every configured stop bit is sampled even if an earlier one was 0.
  - After the last stop sample, register `data_out`, `parity_err` and `frame_err`, and pulse `rx_done`.
  - Next state: IDLE if all stop bits were 1, else WAIT_IDLE.
- **WAIT_IDLE:** stay until `s == 1`, then go to IDLE. This prevents resynchronising inside a break or corrupt frame.
- **Holding behaviour:**
  - The error flags hold their value until the next `rx_done`.
  - `data_out` holds until the next `rx_done`.
  - The internal shift register may change mid-frame, but `data_out` is only updated at `rx_done`.

## Timing
- **Reset:** while `rst` = 1 at a clock edge:
  - state = IDLE; counters = 0; synchroniser = 1;
  - `data_out` = 0, `rx_done` = 0, `parity_err` = 0, `frame_err` = 0, `busy` = 0.
  - Reset mid-frame discards the partial frame; no `rx_done` is produced.
- **Latency:** `rx_done` is high in the cycle `2 + floor(CPB/2) + (L-1)*CPB + 1` after `serial_in` first goes low, where L = frame length in bits. For CPB = 1 this is L + 2.
- **Frame length:** L = 1 + (7|8) + parity_en + (1|2).
- **Back-to-back frames:** in the `rx_done` cycle the FSM is already in IDLE and may detect a new start bit that cycle. Zero idle gap between frames is supported.
- **busy:**
  - rises the cycle after start detection;
  - falls in the `rx_done` cycle when returning to IDLE;
  - on the WAIT_IDLE path, falls after `s` returns high.
- **Output timing:** all outputs are registered; no combinational path from inputs to outputs.

## Test plan
- **8N1, `0xF0`, CPB = 1:** drive from `tx` → `data_out` = `0xF0` with no error flags. Then `0x5A` → `data_out` = `0x5A`, no errors, `rx_done` exactly 12 cycles after `serial_in` first low.
- **8O1, `0x0F`:** parity bit 1 → `data_out` = `0x0F`, `parity_err` = 0. Force the parity bit to 0 → `parity_err` = 1, `data_out` still `0x0F`, `frame_err` = 0.
- **7O2, `0x2A` (parity bit 0, L = 11):** `data_out` = `0x2A`, `rx_done` 13 cycles after start. Then 7N1 `0xAA` from `tx` → `data_out` = `0x2A` (bit 7 dropped).
- **Frame error:** 8N1 `0xF0` with the stop bit forced 0 and the line held low 5 extra cycles → one `rx_done` with `frame_err` = 1; `busy` stays high until the line returns high; no second `rx_done`.
- **Back-to-back:** two 8N2 frames, `0x9E` then `0x01`, with no gap → two `rx_done` pulses 11 cycles apart, data `0x9E` then `0x01`, no errors.
- **CPB = 4:**
  - 1-cycle low glitch → false start rejected; `busy` returns low within 4 cycles; no `rx_done`.
  - `rst` asserted during data bit 3 → all outputs 0 next cycle; no `rx_done`.
  - A following clean frame `0x5A` is received correctly.
